// File: rtl/sram_param.sv
// sram_param: parametrised synchronous-write SRAM model
// with per-bit write mask, optional read register and clear sequencer.
module sram_param #(
  parameter int                 DATA_W   = 4,
  parameter int                 ADDR_W   = 10,
  parameter int                 READ_LAT = 0,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              cs_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] wmask,
  input  logic              clear_req,
  output logic [DATA_W-1:0] dout,
  output logic              dout_oe,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  localparam logic [ADDR_W:0] CLR_LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] CLR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [0:0]        r_state;
  logic [ADDR_W:0]   r_clr_addr;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_wr;
  logic [DATA_W-1:0] w_rd;
  logic [DATA_W-1:0] w_merge;

  assign busy    = (r_state == S_CLEAR);
  assign w_wr    = ~busy & ~cs_b & ~we_b;
  assign w_rd    = r_mem[addr];
  assign w_merge = (w_rd & ~wmask) | (din & wmask);

  // Clear sequencer: sweep every address once, then idle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
    end else begin
      unique case (r_state)
        S_CLEAR: begin
          r_clr_addr <= r_clr_addr + CLR_ONE;
          if (r_clr_addr == CLR_LAST) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          if (clear_req) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
          end
        end
      endcase
    end
  end

  // Array update: sweep fill while busy, masked external write otherwise.
  always_ff @(posedge clk) begin
    if (busy) begin
      r_mem[r_clr_addr[ADDR_W-1:0]] <= INIT_VAL;
    end else if (w_wr) begin
      r_mem[addr] <= w_merge;
    end
  end

  generate
    if (READ_LAT == 0) begin : g_comb_rd
      assign dout    = busy ? INIT_VAL : w_rd;
      assign dout_oe = ~cs_b & ~busy;
    end else begin : g_reg_rd
      logic [DATA_W-1:0] r_dout;
      logic              r_dout_oe;

      // Registered read port, write-first on a same-edge write.
      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          r_dout    <= INIT_VAL;
          r_dout_oe <= 1'b0;
        end else begin
          r_dout_oe <= ~cs_b & ~busy;
          if (busy) begin
            r_dout <= INIT_VAL;
          end else if (w_wr) begin
            r_dout <= w_merge;
          end else begin
            r_dout <= w_rd;
          end
        end
      end

      assign dout    = r_dout;
      assign dout_oe = r_dout_oe;
    end
  endgenerate

endmodule

// File: tb/tb_sram_param.sv
// tb_sram_param: checks a combinational-read and a registered-read
// sram_param side by side against a word-level reference model.
module tb_sram_param;

  localparam int         DW   = 4;
  localparam int         AW   = 4;
  localparam int         NW   = 16;
  localparam logic [3:0] INIT = 4'hA;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          cs_b;
  logic          we_b;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] wmask;
  logic          clear_req;

  logic [DW-1:0] dout0, dout1;
  logic          oe0, oe1;
  logic          busy0, busy1;

  int n_chk = 0;
  int n_err = 0;

  logic [3:0] m_mem [NW];
  int         m_left;
  logic [3:0] exp_d1;
  logic       exp_o1;

  always #5 clk = ~clk;

  sram_param #(
    .DATA_W(DW), .ADDR_W(AW), .READ_LAT(0), .INIT_VAL(INIT)
  ) u_dut0 (
    .clk(clk), .rst_b(rst_b), .cs_b(cs_b), .we_b(we_b),
    .addr(addr), .din(din), .wmask(wmask),
    .clear_req(clear_req),
    .dout(dout0), .dout_oe(oe0), .busy(busy0)
  );

  sram_param #(
    .DATA_W(DW), .ADDR_W(AW), .READ_LAT(1), .INIT_VAL(INIT)
  ) u_dut1 (
    .clk(clk), .rst_b(rst_b), .cs_b(cs_b), .we_b(we_b),
    .addr(addr), .din(din), .wmask(wmask),
    .clear_req(clear_req),
    .dout(dout1), .dout_oe(oe1), .busy(busy1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic m_fill();
    for (int i = 0; i < NW; i++) m_mem[i] = INIT;
  endtask

  task automatic chk_comb();
    logic bz;
    bz = (m_left > 0);
    chk("busy0", 32'(busy0), 32'(bz));
    chk("dout0", 32'(dout0), 32'(bz ? INIT : m_mem[addr]));
    chk("oe0", 32'(oe0), 32'(!cs_b && !bz));
  endtask

  task automatic idle_in();
    cs_b = 1'b1; we_b = 1'b1; addr = '0;
    din = '0; wmask = '1; clear_req = 1'b0;
  endtask

  // One rising edge with the current inputs; model advances in step.
  task automatic step();
    logic       wr;
    logic [3:0] mrg;
    logic [3:0] nd;
    logic       no;
    #1;
    chk_comb();
    wr  = rst_b && (m_left == 0) && !cs_b && !we_b;
    mrg = (m_mem[addr] & ~wmask) | (din & wmask);
    if (!rst_b || m_left > 0) begin
      nd = INIT; no = 1'b0;
    end else begin
      nd = wr ? mrg : m_mem[addr];
      no = !cs_b;
    end
    @(posedge clk);
    #1;
    if (!rst_b) begin
      m_left = NW;
    end else if (m_left > 0) begin
      m_left--;
    end else begin
      if (wr) m_mem[addr] = mrg;
      if (clear_req) begin
        m_left = NW;
        m_fill();
      end
    end
    exp_d1 = nd;
    exp_o1 = no;
    chk("busy1", 32'(busy1), 32'(m_left > 0));
    chk("dout1", 32'(dout1), 32'(exp_d1));
    chk("oe1", 32'(oe1), 32'(exp_o1));
    chk_comb();
  endtask

  task automatic assert_rst();
    rst_b  = 1'b0;
    m_left = NW;
    m_fill();
    exp_d1 = INIT;
    exp_o1 = 1'b0;
    #1;
    chk("rst_busy", 32'(busy0 & busy1), 32'd1);
    chk("rst_oe", 32'({oe0, oe1}), 32'd0);
    chk("rst_dout1", 32'(dout1), 32'(INIT));
    chk("rst_dout0", 32'(dout0), 32'(INIT));
  endtask

  task automatic wr_word(input logic [3:0] a,
                         input logic [3:0] d,
                         input logic [3:0] m);
    cs_b = 1'b0; we_b = 1'b0; addr = a;
    din = d; wmask = m; clear_req = 1'b0;
    step();
    idle_in();
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (busy0 && n < 40) begin
      step();
      n++;
    end
    chk(tag, 32'(n), 32'(NW));
  endtask

  task automatic read_all(input string tag);
    cs_b = 1'b0; we_b = 1'b1;
    for (int i = 0; i < NW; i++) begin
      addr = 4'(i);
      #1;
      chk(tag, 32'(dout0), 32'(INIT));
      step();
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    rst_b  = 1'b1;
    m_left = NW;
    m_fill();
    #2;
    assert_rst();
    step();
    step();
    rst_b = 1'b1;
    count_busy("rst_clr_len");
    read_all("rst_clr_rd");

    // Masked writes, combinational port.
    wr_word(4'd3, 4'hF, 4'b0101);
    cs_b = 1'b0; addr = 4'd3; #1;
    chk("mask1", 32'(dout0), 32'h0F);
    idle_in();
    wr_word(4'd3, 4'h0, 4'b0011);
    cs_b = 1'b0; addr = 4'd3; #1;
    chk("mask2", 32'(dout0), 32'h0C);
    cs_b = 1'b1; #1;
    chk("oe0_desel", 32'(oe0), 32'd0);
    idle_in();

    // Read-during-write, registered port.
    wr_word(4'd5, 4'h2, 4'hF);
    wr_word(4'd5, 4'h7, 4'hF);
    chk("rdw_d1", 32'(dout1), 32'h07);
    chk("rdw_oe1", 32'(oe1), 32'd1);
    cs_b = 1'b1; addr = 4'd5;
    step();
    chk("desel_oe1", 32'(oe1), 32'd0);

    // Writes dropped during a sweep; second request ignored.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    begin
      int n;
      n = 0;
      while (busy0 && n < 40) begin
        if (n == 3) begin
          cs_b = 1'b0; we_b = 1'b0; addr = 4'd2;
          din = 4'h5; wmask = 4'hF;
        end else if (n == 8) begin
          idle_in();
          clear_req = 1'b1;
        end else begin
          idle_in();
        end
        step();
        n++;
      end
      idle_in();
      chk("req_clr_len", 32'(n), 32'(NW));
    end
    cs_b = 1'b0; addr = 4'd2; #1;
    chk("blocked_wr", 32'(dout0), 32'(INIT));
    idle_in();

    // Simultaneous clear request and write.
    cs_b = 1'b0; we_b = 1'b0; addr = 4'd0;
    din = 4'h9; wmask = 4'hF; clear_req = 1'b1;
    step();
    idle_in();
    count_busy("sim_clr_len");
    cs_b = 1'b0; addr = 4'd0; #1;
    chk("sim_clr_a0", 32'(dout0), 32'(INIT));
    idle_in();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cs_b      = ($urandom_range(3) == 0);
      we_b      = $urandom_range(1) == 1;
      addr      = 4'($urandom);
      din       = 4'($urandom);
      wmask     = 4'($urandom);
      clear_req = ($urandom_range(49) == 0);
      step();
    end
    idle_in();
    while (busy0 && m_left > 0) step();

    // Dirty the array, then reset in the middle of a sweep.
    for (int i = 0; i < NW; i++) begin
      wr_word(4'(i), 4'(i ^ 5), 4'hF);
    end
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int i = 0; i < 7; i++) step();
    assert_rst();
    step();
    step();
    rst_b = 1'b1;
    count_busy("midrst_len");
    read_all("midrst_rd");

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
